// File: rtl/colour_pkg.sv
// ============================================================================
// Module   : colour_pkg
// Brief    : Shared types, index names and the fixed MC6847-style palette
//            for the colour_mux video path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package colour_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb333_t;

  typedef logic [3:0] colour_idx_t;

  localparam int unsigned PALETTE_DEPTH = 16;

  localparam colour_idx_t COL_BLACK       = 4'd0;
  localparam colour_idx_t COL_GREEN       = 4'd1;
  localparam colour_idx_t COL_YELLOW      = 4'd2;
  localparam colour_idx_t COL_BLUE        = 4'd3;
  localparam colour_idx_t COL_RED         = 4'd4;
  localparam colour_idx_t COL_BUFF        = 4'd5;
  localparam colour_idx_t COL_CYAN        = 4'd6;
  localparam colour_idx_t COL_MAGENTA     = 4'd7;
  localparam colour_idx_t COL_ORANGE      = 4'd8;
  localparam colour_idx_t COL_DARK_GREEN  = 4'd9;
  localparam colour_idx_t COL_DARK_ORANGE = 4'd10;
  localparam colour_idx_t COL_WHITE       = 4'd11;

  // Entries 12..15 are unused indices and deliberately decode to black.
  localparam rgb333_t DEFAULT_PALETTE [PALETTE_DEPTH] = '{
    '{3'b000, 3'b000, 3'b000},
    '{3'b000, 3'b111, 3'b000},
    '{3'b111, 3'b111, 3'b000},
    '{3'b000, 3'b000, 3'b111},
    '{3'b111, 3'b000, 3'b000},
    '{3'b111, 3'b111, 3'b110},
    '{3'b000, 3'b111, 3'b111},
    '{3'b111, 3'b000, 3'b111},
    '{3'b111, 3'b100, 3'b000},
    '{3'b000, 3'b011, 3'b000},
    '{3'b011, 3'b001, 3'b000},
    '{3'b111, 3'b111, 3'b111},
    '{3'b000, 3'b000, 3'b000},
    '{3'b000, 3'b000, 3'b000},
    '{3'b000, 3'b000, 3'b000},
    '{3'b000, 3'b000, 3'b000}
  };

  function automatic rgb333_t default_colour(input colour_idx_t idx);
    return DEFAULT_PALETTE[idx];
  endfunction

endpackage

`default_nettype wire

// File: rtl/colour_palette_rf.sv
// ============================================================================
// Module   : colour_palette_rf
// Brief    : 16x9 writable palette, reset to the default table; combinational
//            read so a same-index write is seen only from the next edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module colour_palette_rf
  import colour_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  colour_idx_t wr_addr,
  input  rgb333_t     wr_data,
  input  colour_idx_t rd_addr,
  output rgb333_t     rd_data
);

  rgb333_t r_mem [PALETTE_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PALETTE_DEPTH; i++) begin
        r_mem[i] <= DEFAULT_PALETTE[i];
      end
    end else if (we) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/colour_mux.sv
// ============================================================================
// Module   : colour_mux
// Brief    : Colour index to RGB333 mapper with blanking override.
//            Optional writable palette under macro PALETTE_WRITE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module colour_mux
  import colour_pkg::*;
#(
  parameter int unsigned REG_OUT   = 1,
  parameter logic [8:0]  BLANK_RGB = 9'h000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] colourIndex,
  input  logic       blank,
  output logic [8:0] rgbdata
`ifdef PALETTE_WRITE_EN
  ,
  input  logic       palWe,
  input  logic [3:0] palAddr,
  input  logic [8:0] palData
`endif
);

  rgb333_t    w_pal_rgb;
  logic [8:0] w_pixel;

`ifdef PALETTE_WRITE_EN
  colour_palette_rf u_palette (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (palWe),
    .wr_addr (palAddr),
    .wr_data (rgb333_t'(palData)),
    .rd_addr (colourIndex),
    .rd_data (w_pal_rgb)
  );
`else
  assign w_pal_rgb = default_colour(colourIndex);
`endif

  assign w_pixel = blank ? BLANK_RGB : w_pal_rgb;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [8:0] r_rgb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rgb <= 9'h000;
        end else begin
          r_rgb <= w_pixel;
        end
      end

      assign rgbdata = r_rgb;
    end else begin : g_comb_out
      // Reset still forces black on the combinational path.
      assign rgbdata = rst_n ? w_pixel : 9'h000;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_colour_mux.sv
// ============================================================================
// Module   : tb_colour_mux
// Brief    : Self-checking bench for colour_mux, registered and combinational
//            builds side by side. Honours macro PALETTE_WRITE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_colour_mux;

  localparam logic [8:0] BLANK_C = 9'h0A5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       blank = 1'b0;
  logic [3:0] idx   = 4'd0;
  logic [8:0] rgb_reg;
  logic [8:0] rgb_comb;
`ifdef PALETTE_WRITE_EN
  logic       pal_we   = 1'b0;
  logic [3:0] pal_addr = 4'd0;
  logic [8:0] pal_data = 9'h000;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  colour_mux #(.REG_OUT(1), .BLANK_RGB(9'h000)) u_dut_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .colourIndex (idx),
    .blank       (blank),
    .rgbdata     (rgb_reg)
`ifdef PALETTE_WRITE_EN
    ,
    .palWe       (pal_we),
    .palAddr     (pal_addr),
    .palData     (pal_data)
`endif
  );

  colour_mux #(.REG_OUT(0), .BLANK_RGB(BLANK_C)) u_dut_comb (
    .clk         (clk),
    .rst_n       (rst_n),
    .colourIndex (idx),
    .blank       (blank),
    .rgbdata     (rgb_comb)
`ifdef PALETTE_WRITE_EN
    ,
    .palWe       (pal_we),
    .palAddr     (pal_addr),
    .palData     (pal_data)
`endif
  );

  function automatic logic [8:0] def_rgb(input logic [3:0] i);
    case (i)
      4'd1:    return 9'h038;
      4'd2:    return 9'h1F8;
      4'd3:    return 9'h007;
      4'd4:    return 9'h1C0;
      4'd5:    return 9'h1FE;
      4'd6:    return 9'h03F;
      4'd7:    return 9'h1C7;
      4'd8:    return 9'h1E0;
      4'd9:    return 9'h018;
      4'd10:   return 9'h0C8;
      4'd11:   return 9'h1FF;
      default: return 9'h000;
    endcase
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: palette contents plus the value the registered output must show.
  logic [8:0] mdl_pal [16];
  logic [8:0] exp_reg = 9'h000;

  initial begin
    for (int i = 0; i < 16; i++) mdl_pal[i] = def_rgb(4'(i));
  end

  always @(negedge rst_n) begin
    exp_reg = 9'h000;
    for (int i = 0; i < 16; i++) mdl_pal[i] = def_rgb(4'(i));
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_reg = 9'h000;
    end else begin
      exp_reg = blank ? 9'h000 : mdl_pal[idx];
`ifdef PALETTE_WRITE_EN
      if (pal_we) mdl_pal[pal_addr] = pal_data;
`endif
    end
  end

  always @(posedge clk) begin
    #2;
    check("reg_vs_model", rgb_reg, exp_reg);
    check("comb_vs_model", rgb_comb, !rst_n ? 9'h000 : (blank ? BLANK_C : mdl_pal[idx]));
  end

  task automatic drive(input logic [3:0] i, input logic b);
    @(negedge clk);
    idx   = i;
    blank = b;
  endtask

  task automatic expect_next(input string name, input logic [8:0] val);
    @(posedge clk);
    #2;
    check(name, rgb_reg, val);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_hold_reg", rgb_reg, 9'h000);
    check("reset_hold_comb", rgb_comb, 9'h000);

    @(negedge clk);
    rst_n = 1'b1;
    idx   = 4'd1;
    expect_next("first_after_reset", 9'h038);

    drive(4'd4, 1'b0);
    expect_next("idx4_red", 9'h1C0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_reg", rgb_reg, 9'h000);
    check("async_reset_comb", rgb_comb, 9'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idx   = 4'd1;
    expect_next("release_idx1", 9'h038);

    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 1'b0);
      expect_next("sweep", def_rgb(4'(i)));
    end
    drive(4'd8, 1'b0);
    expect_next("idx8_orange", 9'h1E0);
    drive(4'd11, 1'b0);
    expect_next("idx11_white", 9'h1FF);
    drive(4'd13, 1'b0);
    expect_next("idx13_black", 9'h000);

    drive(4'd2, 1'b1);
    expect_next("blank_reg", 9'h000);
    check("blank_comb", rgb_comb, BLANK_C);
    drive(4'd2, 1'b0);
    expect_next("unblank_yellow", 9'h1F8);

    for (int k = 0; k < 8; k++) begin
      drive((k % 2) ? 4'd5 : 4'd0, 1'b0);
      expect_next("semigraphic_alt", (k % 2) ? 9'h1FE : 9'h000);
    end

    @(negedge clk);
    idx = 4'd6;
    #1;
    check("comb_idx6", rgb_comb, 9'h03F);
    idx = 4'd7;
    #1;
    check("comb_idx7", rgb_comb, 9'h1C7);

`ifdef PALETTE_WRITE_EN
    @(negedge clk);
    idx      = 4'd3;
    pal_we   = 1'b1;
    pal_addr = 4'd3;
    pal_data = 9'h155;
    expect_next("rdw_old_value", 9'h007);
    @(negedge clk);
    pal_we = 1'b0;
    expect_next("rdw_new_value", 9'h155);
    check("rdw_new_comb", rgb_comb, 9'h155);

    @(negedge clk);
    rst_n    = 1'b0;
    pal_we   = 1'b1;
    pal_addr = 4'd5;
    pal_data = 9'h0F0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pal_we = 1'b0;
    rst_n  = 1'b1;
    idx    = 4'd3;
    expect_next("pal_reset_idx3", 9'h007);
    drive(4'd5, 1'b0);
    expect_next("write_in_reset_ignored", 9'h1FE);
`endif

    repeat (2) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
